memoria_principal_ctrl: RTL and testbench

Main-memory responder for the L1 cache: the memory-side end of the cache's miss/write-back protocol. It holds a 32×8 backing store and accepts two kinds of request from the cache controller:
- write-backs of dirty lines (dirty tag plus data);
- line fills for misses (address), answered with the stored byte after a fixed latency.

A simultaneous write-back and fill are serialized write-back first, so a fill of the same address returns the freshly written data.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/memoria_principal_array.sv | 37 +++
 rtl/memoria_principal_ctrl.sv | 157 +++++++++++++++
 tb/tb_memoria_principal_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder.
// Ports: none (package) -- default widths, controller state encoding and
// the power-on contents of the backing store.
package mem_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WB      = 2'd1,
      RD_WAIT = 2'd2,
      RD_RESP = 2'd3
   } state_t;

   // Reset contents of the store: every word holds its own address.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a;
   endfunction

endpackage

// File: rtl/memoria_principal_array.sv
// Backing store: 2**ADDR_W x DATA_W words, reset loads mem[a] = a.
// Latency: synchronous write, combinational read (0 cycles).
// Backpressure: none, accepts a write every cycle.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_we, i_waddr,
//        i_wdata write port; i_raddr read address; o_rdata read data.
module memoria_principal_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= DATA_W'(init_word(32'(i)));
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memoria_principal_ctrl.sv
// Memory-side responder for L1 write-backs and line fills.
// Latency: write-back commits LATENCY edges after acceptance, fill data is
//          valid the cycle after edge LATENCY (2*LATENCY when behind a write-back).
// Backpressure: busy_out high from acceptance to completion; requests seen
//          while busy are dropped, the cache must hold them until busy falls.
// Ports: clock_in, reset_n_in (async active-low); rd_req_in/rd_addr_in fill
//        request; wr_req_in/wr_addr_in/wr_data_in write-back request;
//        data_out/data_valid_out fill response; busy_out in-progress flag.
module memoria_principal_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int LATENCY = 2
) (
   input  logic              clock_in,
   input  logic              reset_n_in,
   input  logic              rd_req_in,
   input  logic [ADDR_W-1:0] rd_addr_in,
   input  logic              wr_req_in,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic [DATA_W-1:0] wr_data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid_out,
   output logic              busy_out
);

   // The wait counter is 4 bits wide, so only 1..15 wait cycles fit.
   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("memoria_principal_ctrl: LATENCY must be within 1..15");
   end

   localparam logic [3:0] CNT_RELOAD = 4'(LATENCY - 1);

   state_t            r_state, w_state_nxt;
   logic [3:0]        r_cnt, w_cnt_nxt;
   logic              r_pend_rd, w_pend_rd_nxt;
   logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
   logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
   logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
   logic [DATA_W-1:0] r_data, w_data_nxt;
   logic              r_valid, w_valid_nxt;
   logic              r_busy, w_busy_nxt;
   logic              w_we;
   logic [DATA_W-1:0] w_rd_data;

   memoria_principal_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .i_clk   (clock_in),
      .i_rst_n (reset_n_in),
      .i_we    (w_we),
      .i_waddr (r_wr_addr),
      .i_wdata (r_wr_data),
      .i_raddr (r_rd_addr),
      .o_rdata (w_rd_data)
   );

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_cnt     <= '0;
         r_pend_rd <= 1'b0;
         r_rd_addr <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_pend_rd <= w_pend_rd_nxt;
         r_rd_addr <= w_rd_addr_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pend_rd_nxt = r_pend_rd;
      w_rd_addr_nxt = r_rd_addr;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_data_nxt    = r_data;
      w_valid_nxt   = 1'b0;
      w_busy_nxt    = r_busy;
      w_we          = 1'b0;

      case (r_state)
         IDLE: begin
            if (wr_req_in || rd_req_in) begin
               w_rd_addr_nxt = rd_addr_in;
               w_wr_addr_nxt = wr_addr_in;
               w_wr_data_nxt = wr_data_in;
               w_cnt_nxt     = CNT_RELOAD;
               w_busy_nxt    = 1'b1;
               // Write-back goes first so a same-address fill sees new data.
               if (wr_req_in) begin
                  w_state_nxt   = WB;
                  w_pend_rd_nxt = rd_req_in;
               end else begin
                  w_state_nxt   = RD_WAIT;
               end
            end
         end
         WB: begin
            if (r_cnt == 4'd0) begin
               w_we = 1'b1;
               if (r_pend_rd) begin
                  w_state_nxt   = RD_WAIT;
                  w_cnt_nxt     = CNT_RELOAD;
                  w_pend_rd_nxt = 1'b0;
               end else begin
                  w_state_nxt = IDLE;
                  w_busy_nxt  = 1'b0;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         RD_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_data_nxt  = w_rd_data;
               w_valid_nxt = 1'b1;
               w_state_nxt = RD_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         RD_RESP: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign data_out       = r_data;
   assign data_valid_out = r_valid;
   assign busy_out       = r_busy;

endmodule

// File: tb/tb_memoria_principal_ctrl.sv
module tb_memoria_principal_ctrl;

   localparam int LAT = 2;

   logic       clk;
   logic       rst_n;
   logic       rd_req;
   logic [4:0] rd_addr;
   logic       wr_req;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] data_out;
   logic       data_valid_out;
   logic       busy_out;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];
   int pulses = 0;

   memoria_principal_ctrl #(.ADDR_W(5), .DATA_W(8), .LATENCY(LAT)) dut (
      .clock_in       (clk),
      .reset_n_in     (rst_n),
      .rd_req_in      (rd_req),
      .rd_addr_in     (rd_addr),
      .wr_req_in      (wr_req),
      .wr_addr_in     (wr_addr),
      .wr_data_in     (wr_data),
      .data_out       (data_out),
      .data_valid_out (data_valid_out),
      .busy_out       (busy_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every valid pulse must match the oldest expected fill.
   always @(negedge clk) begin
      if (data_valid_out === 1'b1) begin
         pulses++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse data_out=%h expected no response", data_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               bad++;
               $display("FAIL fill_data got=%h want=%h", data_out, e);
            end
         end
      end
   end

   task automatic wait_idle(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy_out === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   // Drives one request pair at a negedge with the DUT idle; returns just after E0.
   task automatic issue(input logic rd, input logic [4:0] ra, input logic wr,
                        input logic [4:0] wa, input logic [7:0] wd);
      rd_req  = rd;
      rd_addr = ra;
      wr_req  = wr;
      wr_addr = wa;
      wr_data = wd;
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   task automatic test_reset();
      bit to;
      rst_n = 1'b0;
      #3;
      total++;
      if (data_out !== 8'h00 || data_valid_out !== 1'b0 || busy_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_init got=%h/%b/%b want=00/0/0", data_out, data_valid_out, busy_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Read addr 9, let the pulse go out, then reset while busy and data_out nonzero.
      exp_q.push_back(8'h09);
      issue(1'b1, 5'd9, 1'b0, 5'd0, 8'h00);
      repeat (LAT + 1) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (data_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_async_data got=%h want=00", data_out);
      end
      total++;
      if (data_valid_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_async_valid got=%b want=0", data_valid_out);
      end
      total++;
      if (busy_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_async_busy got=%b want=0", busy_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.push_back(8'h16);
      issue(1'b1, 5'b10110, 1'b0, 5'd0, 8'h00);
      wait_idle(to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL reset_read_timeout busy_out=%b want=0", busy_out);
      end
   endtask

   task automatic test_read_latency();
      exp_q.push_back(8'h19);
      issue(1'b1, 5'b11001, 1'b0, 5'd0, 8'h00);
      for (int k = 0; k <= LAT + 2; k++) begin
         @(negedge clk);
         total++;
         if (data_valid_out !== (k == LAT) || busy_out !== (k <= LAT)) begin
            bad++;
            $display("FAIL read_timing after_E%0d valid/busy got=%b/%b want=%b/%b",
                     k, data_valid_out, busy_out, k == LAT, k <= LAT);
         end
         if (k > LAT) begin
            total++;
            if (data_out !== 8'h19) begin
               bad++;
               $display("FAIL read_data_hold after_E%0d got=%h want=19", k, data_out);
            end
         end
      end
   endtask

   task automatic test_wb_then_read();
      bit to;
      issue(1'b0, 5'd0, 1'b1, 5'b10100, 8'hAB);
      for (int k = 0; k <= LAT; k++) begin
         @(negedge clk);
         total++;
         if (busy_out !== (k < LAT) || data_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL wb_timing after_E%0d busy/valid got=%b/%b want=%b/0",
                     k, busy_out, data_valid_out, k < LAT);
         end
      end
      exp_q.push_back(8'hAB);
      issue(1'b1, 5'b10100, 1'b0, 5'd0, 8'h00);
      wait_idle(to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL wb_read_timeout busy_out=%b want=0", busy_out);
      end
   endtask

   task automatic test_simultaneous();
      exp_q.push_back(8'h5C);
      issue(1'b1, 5'b10101, 1'b1, 5'b10101, 8'h5C);
      for (int k = 0; k <= 2 * LAT + 2; k++) begin
         @(negedge clk);
         total++;
         if (data_valid_out !== (k == 2 * LAT) || busy_out !== (k <= 2 * LAT)) begin
            bad++;
            $display("FAIL simul_timing after_E%0d valid/busy got=%b/%b want=%b/%b",
                     k, data_valid_out, busy_out, k == 2 * LAT, k <= 2 * LAT);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int p0;
      p0 = pulses;
      exp_q.push_back(8'h03);
      issue(1'b1, 5'd3, 1'b0, 5'd0, 8'h00);
      // Hold a second fill through every busy edge, drop it before idle.
      rd_req  = 1'b1;
      rd_addr = 5'd7;
      wr_req  = 1'b1;
      wr_addr = 5'd3;
      wr_data = 8'hEE;
      repeat (LAT + 1) @(posedge clk);
      #1;
      rd_req = 1'b0;
      wr_req = 1'b0;
      repeat (8) @(negedge clk);
      total++;
      if (pulses - p0 != 1) begin
         bad++;
         $display("FAIL busy_ignore_pulses got=%0d want=1", pulses - p0);
      end
      total++;
      if (busy_out !== 1'b0) begin
         bad++;
         $display("FAIL busy_ignore_idle got=%b want=0", busy_out);
      end
      // The ignored write-back must not have landed in addr 3.
      exp_q.push_back(8'h03);
      issue(1'b1, 5'd3, 1'b0, 5'd0, 8'h00);
      repeat (LAT + 3) @(negedge clk);
   endtask

   task automatic test_reset_mid_wb();
      bit to;
      issue(1'b0, 5'd0, 1'b1, 5'b00111, 8'hFF);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #3;
      total++;
      if (busy_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_wb_busy got=%b want=0", busy_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.push_back(8'h07);
      issue(1'b1, 5'b00111, 1'b0, 5'd0, 8'h00);
      wait_idle(to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL reset_wb_timeout busy_out=%b want=0", busy_out);
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      for (int a = 28; a < 32; a++) begin
         exp_q.push_back(8'(a));
         issue(1'b1, 5'(a), 1'b0, 5'd0, 8'h00);
         wait_idle(to);
         total++;
         if (to) begin
            bad++;
            $display("FAIL b2b_timeout addr=%0d busy_out=%b want=0", a, busy_out);
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      rd_req  = 1'b0;
      rd_addr = '0;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      test_reset();
      test_read_latency();
      test_wb_then_read();
      test_simultaneous();
      test_busy_ignore();
      test_reset_mid_wb();
      test_back_to_back();
      repeat (5) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_responses got=%0d outstanding want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
